aes_block_loader: RTL and testbench



---
 rtl/aes_block_loader.sv | 118 +++++++++++
 tb/tb_aes_block_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Byte-serial loader for the AES cores: assembles a key and 128-bit blocks
// from an 8-bit valid/ready stream (MSB byte first) and holds each block until consumed.
module aes_block_loader #(
  parameter int BLOCK_BYTES   = 16,
  parameter int MAX_KEY_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   mode,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         key_reload,
  output logic [8*MAX_KEY_BYTES-1:0]   out_key,
  output logic [3:0]                   out_nk,
  output logic [8*BLOCK_BYTES-1:0]     out_state,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int KW    = 8 * MAX_KEY_BYTES;
  localparam int SW    = 8 * BLOCK_BYTES;
  localparam int CNT_W = $clog2(MAX_KEY_BYTES);
  localparam logic [CNT_W-1:0] LAST_STATE = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_STATE,
    PRESENT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] key_last;
  logic             take;
  logic             key_done;
  logic             blk_done;
  logic             reload_now;

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'b10:   nk_of = 4'd6;
      2'b11:   nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] key_last_of(input logic [3:0] nk);
    key_last_of = CNT_W'(int'(nk) * 4 - 1);
  endfunction

  // A reload request closes the input for its own cycle so no byte is half-taken.
  assign reload_now = key_reload && (state != PRESENT);
  assign in_ready   = reset_n && (state != PRESENT) && !key_reload;
  assign take       = in_valid && in_ready;
  assign out_valid  = (state == PRESENT);

  // key_last still holds its reset/old value at cnt 0, but a key is never one byte long.
  assign key_done = take && (state == LOAD_KEY)   && (cnt == key_last);
  assign blk_done = take && (state == LOAD_STATE) && (cnt == LAST_STATE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= LOAD_KEY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_KEY: begin
        if (key_done) state_next = LOAD_STATE;
      end
      LOAD_STATE: begin
        if (key_reload)    state_next = LOAD_KEY;
        else if (blk_done) state_next = PRESENT;
      end
      PRESENT: begin
        if (out_ready) state_next = LOAD_STATE;
      end
      default: state_next = LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      key_last  <= key_last_of(4'd4);
      out_nk    <= 4'd4;
      out_key   <= '0;
      out_state <= '0;
    end else if (reload_now) begin
      // Zeroing the key keeps a shorter next key right-aligned with clean upper bits.
      cnt     <= '0;
      out_key <= '0;
    end else if (take) begin
      case (state)
        LOAD_KEY: begin
          if (cnt == '0) begin
            out_nk   <= nk_of(mode);
            key_last <= key_last_of(nk_of(mode));
          end
          out_key <= {out_key[KW-9:0], in_data};
          cnt     <= key_done ? '0 : cnt + CNT_W'(1);
        end
        LOAD_STATE: begin
          out_state <= {out_state[SW-9:0], in_data};
          cnt       <= blk_done ? '0 : cnt + CNT_W'(1);
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed scenarios plus randomized
// key/block traffic compared against byte-array reference values.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   mode;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         key_reload;
  logic [255:0] out_key;
  logic [3:0]   out_nk;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   kb[32];
  logic [7:0]   sb[16];
  logic [255:0] exp_key;
  logic [3:0]   exp_nk;
  logic [127:0] exp_state;

  always #5 clk = ~clk;

  aes_block_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key_reload (key_reload),
    .out_key    (out_key),
    .out_nk     (out_nk),
    .out_state  (out_state),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int klen(input logic [1:0] m);
    case (m)
      2'b10:   klen = 24;
      2'b11:   klen = 32;
      default: klen = 16;
    endcase
  endfunction

  task automatic idle(input int gap);
    int n;
    n = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   waited;
    acc    = 1'b0;
    waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && waited < 64) begin
      #1;
      acc = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("send_timeout", {255'd0, acc}, 256'd1);
  endtask

  task automatic pulse_reload();
    in_valid   = 1'b0;
    key_reload = 1'b1;
    tick();
    key_reload = 1'b0;
  endtask

  // Key bytes come from kb[]; the first lands in the most significant used byte.
  task automatic load_key(input logic [1:0] m, input logic [1:0] m_after, input int gap);
    int len;
    len  = klen(m);
    mode = m;
    exp_key = '0;
    for (int i = 0; i < len; i++) begin
      idle(gap);
      send_byte(kb[i]);
      mode = m_after;
      exp_key[8*(len-1-i) +: 8] = kb[i];
    end
    exp_nk = 4'(len / 4);
  endtask

  task automatic load_block(input int gap);
    exp_state = '0;
    for (int i = 0; i < 16; i++) begin
      idle(gap);
      if (i == 15) check_eq("valid_early", {255'd0, out_valid}, 256'd0);
      send_byte(sb[i]);
      exp_state[8*(15-i) +: 8] = sb[i];
    end
    check_eq("valid_after_last", {255'd0, out_valid}, 256'd1);
    check_eq("ready_in_present", {255'd0, in_ready}, 256'd0);
  endtask

  task automatic consume(input int delay);
    for (int d = 0; d < delay; d++) begin
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      out_ready = 1'b0;
      tick();
      check_eq("hold_valid", {255'd0, out_valid}, 256'd1);
      check_eq("hold_ready", {255'd0, in_ready}, 256'd0);
      check_eq("hold_state", {128'd0, out_state}, {128'd0, exp_state});
    end
    check_eq("key", out_key, exp_key);
    check_eq("nk", {252'd0, out_nk}, {252'd0, exp_nk});
    check_eq("state", {128'd0, out_state}, {128'd0, exp_state});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("valid_after_take", {255'd0, out_valid}, 256'd0);
    check_eq("ready_after_take", {255'd0, in_ready}, 256'd1);
    check_eq("key_retained", out_key, exp_key);
  endtask

  initial begin
    reset_n    = 1'b0;
    mode       = 2'b01;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    key_reload = 1'b0;
    out_ready  = 1'b0;
    #1;
    check_eq("ready_in_reset", {255'd0, in_ready}, 256'd0);
    tick();
    tick();
    check_eq("rst_valid", {255'd0, out_valid}, 256'd0);
    check_eq("rst_key", out_key, 256'd0);
    check_eq("rst_state", {128'd0, out_state}, 256'd0);
    check_eq("rst_nk", {252'd0, out_nk}, 256'd4);
    reset_n = 1'b1;
    #1;
    check_eq("ready_after_rst", {255'd0, in_ready}, 256'd1);

    // 128-bit key then one block
    for (int i = 0; i < 32; i++) kb[i] = 8'(i);
    for (int i = 0; i < 16; i++) sb[i] = 8'(i * 17);
    load_key(2'b01, 2'b01, 0);
    load_block(0);
    check_eq("t1_key_lit", out_key, 256'h000102030405060708090a0b0c0d0e0f);
    check_eq("t1_state_lit", {128'd0, out_state}, {128'd0, 128'h00112233445566778899aabbccddeeff});
    consume(0);

    // 256-bit key with mode changed after the first byte, then backpressure
    pulse_reload();
    load_key(2'b11, 2'b01, 0);
    load_block(0);
    check_eq("t2_key_lit", out_key, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check_eq("t2_nk", {252'd0, out_nk}, 256'd8);
    consume(5);
    for (int i = 0; i < 16; i++) sb[i] = 8'(255 - i * 17);
    load_block(0);
    check_eq("t3_state_lit", {128'd0, out_state}, {128'd0, 128'hffeeddccbbaa99887766554433221100});
    consume(1);

    // 192-bit key with in_valid toggling every other cycle
    pulse_reload();
    load_key(2'b10, 2'b10, 1);
    load_block(1);
    check_eq("t4_key_lit", out_key, {64'd0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617});
    check_eq("t4_nk", {252'd0, out_nk}, 256'd6);
    consume(0);

    // key_reload after 7 state bytes; the byte offered alongside must be refused
    for (int i = 0; i < 7; i++) send_byte(8'hc0 + 8'(i));
    in_valid   = 1'b1;
    in_data    = 8'h5a;
    key_reload = 1'b1;
    #1;
    check_eq("reload_blocks_byte", {255'd0, in_ready}, 256'd0);
    tick();
    key_reload = 1'b0;
    in_valid   = 1'b0;
    for (int i = 0; i < 16; i++) kb[i] = 8'(15 - i);
    for (int i = 0; i < 16; i++) sb[i] = 8'($urandom);
    load_key(2'b01, 2'b01, 0);
    check_eq("t5_key_lit", out_key, 256'h0f0e0d0c0b0a09080706050403020100);
    load_block(0);
    consume(2);

    // Reset while a block is presented
    load_block(0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("rst2_valid", {255'd0, out_valid}, 256'd0);
    check_eq("rst2_key", out_key, 256'd0);
    check_eq("rst2_state", {128'd0, out_state}, 256'd0);
    check_eq("rst2_nk", {252'd0, out_nk}, 256'd4);
    #1;
    check_eq("rst2_ready", {255'd0, in_ready}, 256'd1);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      logic [1:0] m;
      int nblk;
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, 15);
        for (int i = 0; i < k; i++) send_byte(8'($urandom));
      end
      pulse_reload();
      m = 2'($urandom);
      for (int i = 0; i < 32; i++) kb[i] = 8'($urandom);
      load_key(m, 2'($urandom), -1);
      nblk = $urandom_range(1, 3);
      for (int b = 0; b < nblk; b++) begin
        for (int i = 0; i < 16; i++) sb[i] = 8'($urandom);
        load_block(-1);
        consume($urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
